// File: rtl/fpu_result_logger.sv
// fpu_result_logger
// Captures the FPU add/sub result and its flags into a small circular history
// when the capture key is pressed, and lets the user step through the stored
// entries on the DE2 LED banks with the next key. A level switch clears it.
//
// Ports:
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_z            core result (32 bits)
//   i_overflow     core overflow flag
//   i_underflow    core underflow flag
//   i_zero         core zero flag
//   i_key_capture  raw active-low pushbutton, captures the current result
//   i_key_next     raw active-low pushbutton, steps to the next stored entry
//   i_clear        raw active-high switch, empties the history
//   o_ledr         {6'b0, rd_idx[2:0], z[31], z[26:23], z[22:19]} of shown entry
//   o_ledg         {empty, count[3:0], full, ov, un, zero}
module fpu_result_logger #(
  parameter int unsigned DEPTH           = 8,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_z,
  input  logic        i_overflow,
  input  logic        i_underflow,
  input  logic        i_zero,
  input  logic        i_key_capture,
  input  logic        i_key_next,
  input  logic        i_clear,
  output logic [17:0] o_ledr,
  output logic [8:0]  o_ledg
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 35;

  // Key index 0 = capture, 1 = next
  logic [1:0] key_raw;
  logic [1:0] key_s1;
  logic [1:0] key_s2;
  logic       clr_s1;
  logic       clr_s2;
  logic [1:0] press;

  assign key_raw = {i_key_next, i_key_capture};

  // Two-flop synchronisers; keys idle released (1), clear idle low
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      clr_s1 <= 1'b0;
      clr_s2 <= 1'b0;
    end else begin
      key_s1 <= key_raw;
      key_s2 <= key_s1;
      clr_s1 <= i_clear;
      clr_s2 <= clr_s1;
    end
  end

  // Debouncers: accept a new level after DEBOUNCE_CYCLES stable cycles,
  // then pulse press one cycle after the accepted level falls.
  for (genvar g = 0; g < 2; g++) begin : g_db
    logic        stable;
    logic        stable_d;
    logic        press_q;
    logic [15:0] cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        stable   <= 1'b1;
        stable_d <= 1'b1;
        press_q  <= 1'b0;
        cnt      <= 16'd0;
      end else begin
        stable_d <= stable;
        press_q  <= stable_d & ~stable;
        if (key_s2[g] == stable) begin
          cnt <= 16'd0;
        end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
          stable <= key_s2[g];
          cnt    <= 16'd0;
        end else begin
          cnt <= cnt + 16'd1;
        end
      end
    end

    assign press[g] = press_q;
  end

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_idx;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr_n;
  logic [AW-1:0] rd_idx_n;
  logic [CW-1:0] count_n;
  logic          we_c;

  // Next-state: clear beats capture beats next
  always_comb begin
    wr_ptr_n = wr_ptr;
    rd_idx_n = rd_idx;
    count_n  = count;
    we_c     = 1'b0;
    if (clr_s2) begin
      wr_ptr_n = '0;
      rd_idx_n = '0;
      count_n  = '0;
    end else if (press[0]) begin
      we_c     = 1'b1;
      rd_idx_n = wr_ptr;
      wr_ptr_n = wr_ptr + AW'(1);
      count_n  = (count == CW'(DEPTH)) ? count : count + CW'(1);
    end else if (press[1] && (count != '0)) begin
      // Newest entry wraps back to the oldest; count==DEPTH truncates to 0
      if (rd_idx == wr_ptr - AW'(1)) begin
        rd_idx_n = wr_ptr - AW'(count);
      end else begin
        rd_idx_n = rd_idx + AW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_idx <= rd_idx_n;
      count  <= count_n;
    end
  end

  // History storage; contents are masked by count so no reset is needed
  always_ff @(posedge i_clk) begin
    if (we_c) begin
      mem[wr_ptr] <= {i_z, i_overflow, i_underflow, i_zero};
    end
  end

  logic [EW-1:0] rd_entry_c;
  logic          nonempty_c;
  logic          unused_entry_bits;

  assign rd_entry_c        = mem[rd_idx];
  assign nonempty_c        = (count != '0);
  assign unused_entry_bits = ^{rd_entry_c[33:30], rd_entry_c[21:3]};

  // Registered LED view of the current state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ledr <= 18'h0;
      o_ledg <= 9'h100;
    end else begin
      o_ledr[17:12] <= 6'h0;
      o_ledr[11:9]  <= 3'(rd_idx);
      o_ledr[8:0]   <= nonempty_c ? {rd_entry_c[34], rd_entry_c[29:26], rd_entry_c[25:22]} : 9'h0;
      o_ledg[8]     <= (count == '0);
      o_ledg[7:4]   <= 4'(count);
      o_ledg[3]     <= (count == CW'(DEPTH));
      o_ledg[2:0]   <= nonempty_c ? rd_entry_c[2:0] : 3'b000;
    end
  end

endmodule
